// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice (two half adders plus OR) consumes one
// operand bit pair per clock and assembles a WIDTH-bit sum LSB first.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       ha_lo;
  logic [1:0]       ha_hi;
  logic             s_bit;
  logic             c_bit;

  // Returns {carry, sum} of a single-bit half addition.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  always_comb begin
    ha_lo = half_add(a_sh[0], b_sh[0]);
    ha_hi = half_add(ha_lo[0], carry);
    s_bit = ha_hi[0];
    c_bit = ha_lo[1] | ha_hi[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= c_bit;
          // Counter stops at LAST so it never wraps while RUN is active.
          if (cnt == LAST) begin
            sum   <= {s_bit, sum_sh[WIDTH-1:1]};
            cout  <= c_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: vector table on an 8-bit instance, corner
// sequences, and an exhaustive sweep of a 4-bit instance.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [7:0] esum;
    logic       ecout;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one operation on the 8-bit DUT; returns the done latency (in
  // cycles after the start edge, -1 on timeout) and the number of busy cycles.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                      output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; cin = tc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, bcnt, seen;
  logic [4:0] exp5;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

    vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_sum4", {cout4, sum4}, 0);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 7; i++) begin
      run8(vecs[i].va, vecs[i].vb, vecs[i].vc, lat, bcnt);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].esum);
      check($sformatf("vec%0d_cout", i), cout, vecs[i].ecout);
      @(negedge clk);
      check($sformatf("vec%0d_done_single", i), done, 0);
      check($sformatf("vec%0d_sum_hold", i), sum, vecs[i].esum);
    end

    // start held high with changing operands during RUN
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    @(posedge clk);
    seen = 0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin a = 8'h11; b = 8'h22; end
      if (k == 6) start = 1'b0;
      if (done) begin
        seen++;
        if (lat < 0) lat = k;
      end
    end
    check("hold_start_latency", lat, 8);
    check("hold_start_done_count", seen, 1);
    check("hold_start_sum", sum, 8'h10);
    check("hold_start_cout", cout, 0);
    check("hold_start_idle", busy, 0);

    // Asynchronous reset mid-RUN at cnt=4
    @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h22; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_sum", sum, 0);
    check("async_reset_cout", cout, 0);
    check("async_reset_done", done, 0);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("post_reset_no_done", seen, 0);
    run8(8'h01, 8'h01, 1'b0, lat, bcnt);
    check("post_reset_latency", lat, 8);
    check("post_reset_sum", sum, 8'h02);
    check("post_reset_cout", cout, 0);

    // Back-to-back: new start accepted in the DONE cycle
    run8(8'h10, 8'h20, 1'b0, lat, bcnt);
    check("b2b_first_latency", lat, 8);
    check("b2b_first_sum", sum, 8'h30);
    check("b2b_first_cout", cout, 0);
    start = 1'b1; a = 8'hF0; b = 8'h20; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_dropped", done, 0);
    check("b2b_busy_again", busy, 1);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) check("b2b_sum_stable_in_run", sum, 8'h30);
      if (done) begin
        lat = k;
        break;
      end
    end
    check("b2b_second_latency", lat, 8);
    check("b2b_second_sum", sum, 8'h10);
    check("b2b_second_cout", cout, 1);

    // Exhaustive 4-bit sweep
    for (int v = 0; v < 512; v++) begin
      @(negedge clk);
      start4 = 1'b1; a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8];
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      lat = -1;
      for (int k = 0; k < 12; k++) begin
        if (k > 0) @(negedge clk);
        if (done4) begin
          lat = k;
          break;
        end
      end
      exp5 = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
      if (lat != 4) check($sformatf("w4_latency_%0d", v), lat, 4);
      check($sformatf("w4_result_%0d", v), {cout4, sum4}, exp5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
